// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - slice opmode constants and sequencer state encoding
package fir_seq_pkg;
   localparam logic [7:0] OP_CLR   = 8'h00;
   localparam logic [7:0] OP_FIRST = 8'h01;
   localparam logic [7:0] OP_ACC   = 8'h09;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;
endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - NTAPS x 18 coefficient register file, write-protected while busy
module fir_coef_bank #(
   parameter int NTAPS = 4,
   parameter int KW    = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          we,
   input  logic          busy,
   input  logic [3:0]    addr,
   input  logic [17:0]   wdata,
   input  logic [KW-1:0] raddr,
   output logic [17:0]   rdata
);
   logic [17:0] mem [NTAPS];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
      end else if (we && !busy && ({28'd0, addr} < 32'(NTAPS))) begin
         mem[addr[KW-1:0]] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/dsp_fir_sequencer.sv
// rtl/dsp_fir_sequencer.sv - streams FIR taps into a pipelined MAC slice and returns the sum
module dsp_fir_sequencer import fir_seq_pkg::*; #(
   parameter int NTAPS       = 4,
   parameter int DSP_LATENCY = 3,
   parameter int OPMODE_LAG  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [17:0] s_data,
   input  logic        coef_we,
   input  logic [3:0]  coef_addr,
   input  logic [17:0] coef_data,
   output logic        coef_busy,
   output logic [17:0] dsp_a,
   output logic [17:0] dsp_b,
   output logic [7:0]  dsp_opmode,
   input  logic [47:0] dsp_p,
   output logic        y_valid,
   input  logic        y_ready,
   output logic [47:0] y_data
);
   localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int CW = $clog2(DSP_LATENCY + 1);

   state_t        state;
   logic [KW-1:0] k;
   logic [CW-1:0] cnt;
   logic [17:0]   x [NTAPS];
   logic [17:0]   h_k;
   logic [7:0]    op_next;
   logic [7:0]    op_pipe [OPMODE_LAG];

   fir_coef_bank #(.NTAPS(NTAPS), .KW(KW)) u_coef (
      .CLK   (CLK),
      .RST   (RST),
      .we    (coef_we),
      .busy  (coef_busy),
      .addr  (coef_addr),
      .wdata (coef_data),
      .raddr (k),
      .rdata (h_k)
   );

   assign s_ready    = (state == IDLE);
   assign coef_busy  = (state == RUN) || (state == DRAIN);
   assign dsp_a      = (state == RUN) ? x[k] : '0;
   assign dsp_b      = (state == RUN) ? h_k  : '0;
   assign dsp_opmode = op_pipe[OPMODE_LAG-1];

   // Opmode as it would be if OPMODEREG had no lag; the pipe realigns it with M.
   always_comb begin
      op_next = OP_CLR;
      case (state)
         RUN:     op_next = (k == '0) ? OP_FIRST : OP_ACC;
         DRAIN:   op_next = OP_ACC;
         default: op_next = OP_CLR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < OPMODE_LAG; i++) op_pipe[i] <= OP_CLR;
      end else begin
         op_pipe[0] <= op_next;
         for (int i = 1; i < OPMODE_LAG; i++) op_pipe[i] <= op_pipe[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         k       <= '0;
         cnt     <= '0;
         y_valid <= 1'b0;
         y_data  <= '0;
         for (int i = 0; i < NTAPS; i++) x[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  x[0] <= s_data;
                  for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (k == KW'(NTAPS - 1)) begin
                  cnt   <= CW'(DSP_LATENCY);
                  state <= DRAIN;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DRAIN: begin
               cnt <= cnt - 1'b1;
               // Last tap's product has just landed on P.
               if (cnt == CW'(1)) begin
                  y_data  <= dsp_p;
                  y_valid <= 1'b1;
                  state   <= OUT;
               end
            end
            OUT: begin
               if (y_ready) begin
                  y_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
